// File: rtl/vedic_mul16_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vedic_mul16_seq_ctrl_if
//  Brief    : Request/result handshake bundle for the sequential 16x16
//             Vedic multiplier controller, with status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface vedic_mul16_seq_ctrl_if #(
    parameter int OP_W  = 16,
    parameter int CNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_a;
    logic [OP_W-1:0]     in_b;
    logic                in_signed;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [2*OP_W-1:0]   out_p;
    logic                busy;
    logic [CNT_W-1:0]    done_cnt;

    // Controller side
    modport slave (
        input  in_valid, in_a, in_b, in_signed, flush, out_ready,
        output in_ready, out_valid, out_p, busy, done_cnt
    );

    // Request source / result sink side
    modport master (
        output in_valid, in_a, in_b, in_signed, flush, out_ready,
        input  in_ready, out_valid, out_p, busy, done_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vedic_mul16_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vedic_mul16_seq_ctrl
//  Brief    : Multi-cycle 16x16 multiplier that time-shares one combinational
//             8x8 Vedic multiplier over four partial products, accumulates
//             them with shifts and applies optional sign correction.
//  Revision : 1.0 - initial release
// ============================================================================

// 8x8 Vedic multiplier: four 4x4 vertical/crosswise products combined.
module vedic_mul8 (
    input  wire logic [7:0]  i_a,
    input  wire logic [7:0]  i_b,
    output logic      [15:0] o_p
);
    logic [7:0] w_ll;
    logic [7:0] w_lh;
    logic [7:0] w_hl;
    logic [7:0] w_hh;

    assign w_ll = {4'b0, i_a[3:0]} * {4'b0, i_b[3:0]};
    assign w_lh = {4'b0, i_a[3:0]} * {4'b0, i_b[7:4]};
    assign w_hl = {4'b0, i_a[7:4]} * {4'b0, i_b[3:0]};
    assign w_hh = {4'b0, i_a[7:4]} * {4'b0, i_b[7:4]};
    assign o_p  = {8'b0, w_ll} + {4'b0, w_lh, 4'b0} + {4'b0, w_hl, 4'b0} + {w_hh, 8'b0};
endmodule

module vedic_mul16_seq_ctrl #(
    parameter int OP_W    = 16,
    parameter bit SIGN_EN = 1'b1,
    parameter int CNT_W   = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    vedic_mul16_seq_ctrl_if.slave        bus
);
    localparam int            HALF   = OP_W / 2;
    localparam int            P_W    = 2 * OP_W;

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_MUL  = 2'd1;
    localparam logic [1:0]    S_FIX  = 2'd2;
    localparam logic [1:0]    S_DONE = 2'd3;

    localparam logic [OP_W-1:0]  C_ONE_OP = 1;
    localparam logic [P_W-1:0]   C_ONE_P  = 1;
    localparam logic [CNT_W-1:0] C_ONE_C  = 1;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [1:0]         r_step;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic               r_neg;
    logic [P_W-1:0]     r_acc;
    logic [P_W-1:0]     r_out_p;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_done_cnt;

    logic               w_sa;
    logic               w_sb;
    logic [OP_W-1:0]    w_a_mag;
    logic [OP_W-1:0]    w_b_mag;
    logic [HALF-1:0]    w_ma;
    logic [HALF-1:0]    w_mb;
    logic [4:0]         w_shift;
    logic [OP_W-1:0]    w_pp;
    logic [P_W-1:0]     w_term;
    logic               w_accept;
    logic               w_handshake;

    // Operand sign detection; magnitude in 16-bit unsigned so -32768 -> 0x8000
    assign w_sa    = SIGN_EN && bus.in_signed && bus.in_a[OP_W-1];
    assign w_sb    = SIGN_EN && bus.in_signed && bus.in_b[OP_W-1];
    assign w_a_mag = w_sa ? (~bus.in_a + C_ONE_OP) : bus.in_a;
    assign w_b_mag = w_sb ? (~bus.in_b + C_ONE_OP) : bus.in_b;

    assign w_accept    = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
    assign w_handshake = (r_state == S_DONE) && bus.out_ready && !bus.flush;

    // Partial-product operand and shift selection by step
    always_comb begin
        w_ma    = r_a[HALF-1:0];
        w_mb    = r_b[HALF-1:0];
        w_shift = 5'd0;
        case (r_step)
            2'd0: begin w_ma = r_a[HALF-1:0];    w_mb = r_b[HALF-1:0];    w_shift = 5'd0;  end
            2'd1: begin w_ma = r_a[HALF-1:0];    w_mb = r_b[OP_W-1:HALF]; w_shift = 5'd8;  end
            2'd2: begin w_ma = r_a[OP_W-1:HALF]; w_mb = r_b[HALF-1:0];    w_shift = 5'd8;  end
            default: begin w_ma = r_a[OP_W-1:HALF]; w_mb = r_b[OP_W-1:HALF]; w_shift = 5'd16; end
        endcase
    end

    vedic_mul8 u_mul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_pp)
    );

    assign w_term = {{(P_W-OP_W){1'b0}}, w_pp} << w_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)   w_next = S_MUL;
            S_MUL:   if (r_step == 2'd3) w_next = S_FIX;
            S_FIX:                       w_next = S_DONE;
            default: if (bus.out_ready)  w_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next = S_IDLE;
        end
    end

    // State-decoded outputs
    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        if (r_state == S_IDLE) begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
        end
    end

    // Datapath: operand capture, accumulation, sign fix, result and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step      <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
            r_done_cnt  <= '0;
        end else if (bus.flush) begin
            r_step      <= 2'd0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a_mag;
                r_b   <= w_b_mag;
                r_neg <= w_sa ^ w_sb;
                r_acc <= '0;
                r_step <= 2'd0;
            end
            if (r_state == S_MUL) begin
                r_acc  <= r_acc + w_term;
                r_step <= r_step + 2'd1;
            end
            if (r_state == S_FIX) begin
                r_out_p     <= r_neg ? (~r_acc + C_ONE_P) : r_acc;
                r_out_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_done_cnt  <= r_done_cnt + C_ONE_C;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;
    assign bus.done_cnt  = r_done_cnt;
endmodule
`default_nettype wire

// File: tb/tb_vedic_mul16_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vedic_mul16_seq_ctrl
//  Brief    : Self-checking bench for vedic_mul16_seq_ctrl; a signed and an
//             unsigned-only instance run in lockstep against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_mul16_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   exp_done;

    vedic_mul16_seq_ctrl_if #(.OP_W(16), .CNT_W(8)) bus  ();
    vedic_mul16_seq_ctrl_if #(.OP_W(16), .CNT_W(8)) bus1 ();

    vedic_mul16_seq_ctrl #(.OP_W(16), .SIGN_EN(1'b1), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vedic_mul16_seq_ctrl #(.OP_W(16), .SIGN_EN(1'b0), .CNT_W(8)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Unsigned-only instance sees exactly the same stimulus
    assign bus1.in_valid  = bus.in_valid;
    assign bus1.in_a      = bus.in_a;
    assign bus1.in_b      = bus.in_b;
    assign bus1.in_signed = bus.in_signed;
    assign bus1.flush     = bus.flush;
    assign bus1.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input bit en);
        longint pa;
        longint pb;
        longint pr;
        if (en && s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({48'b0, a});
            pb = longint'({48'b0, b});
        end
        pr = pa * pb;
        return pr[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int stall, output logic [31:0] p0, output logic [31:0] p1);
        int lat;
        chk("in_ready_idle", bus.in_ready, 1);
        start_op(a, b, s);
        chk("busy_after_accept", bus.busy, 1);
        wait_valid(lat);
        chk("latency", lat, 5);
        p0 = bus.out_p;
        p1 = bus1.out_p;
        chk("prod_signed_inst", p0, ref_mul(a, b, s, 1'b1));
        chk("prod_unsigned_inst", p1, ref_mul(a, b, s, 1'b0));
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_p", bus.out_p, p0);
                chk("hold_in_ready", bus.in_ready, 0);
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_done++;
        chk("valid_drop", bus.out_valid, 0);
        chk("in_ready_after", bus.in_ready, 1);
        chk("done_cnt", bus.done_cnt, exp_done % 256);
        chk("done_cnt_u", bus1.done_cnt, exp_done % 256);
    endtask

    initial begin
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        bit          seen;
        n_cmp = 0;
        n_err = 0;
        exp_done = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_signed = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_p", bus.out_p, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done_cnt", bus.done_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed products
        do_op(16'd100, 16'd100, 1'b0, 0, p0, p1);
        chk("t1_100x100", p0, 32'd10000);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, p0, p1);
        chk("t2_ffff_sq", p0, 32'hFFFE0001);
        do_op(16'h00FF, 16'h0100, 1'b0, 0, p0, p1);
        chk("t2_shift8", p0, 32'h0000FF00);
        do_op(16'h8000, 16'h8000, 1'b1, 0, p0, p1);
        chk("t3_min_sq", p0, 32'h40000000);
        do_op(16'hFFFD, 16'd7, 1'b1, 0, p0, p1);
        chk("t3_m3x7", p0, 32'hFFFFFFEB);
        chk("t3_sign_dis", p1, 32'h0006FFEB);
        do_op(16'd0, 16'hFFFB, 1'b1, 0, p0, p1);
        chk("t3_zero_neg", p0, 32'd0);

        // Back-pressure for 10 cycles with a competing request
        do_op(16'd1234, 16'd567, 1'b0, 10, p0, p1);
        chk("t4_bp_prod", p0, 32'd699678);

        // Flush during MUL step 2
        start_op(16'd300, 16'd300, 1'b0);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle_ready", bus.in_ready, 1);
        chk("flush_idle_busy", bus.busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("flush_no_valid", seen, 0);
        chk("flush_done_cnt", bus.done_cnt, exp_done % 256);

        // Flush together with in_valid in IDLE: not accepted
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_vs_valid", bus.busy, 0);
        do_op(16'd50, 16'd50, 1'b0, 0, p0, p1);
        chk("t5_50x50", p0, 32'd2500);

        // Flush in DONE with out_ready high: no count, out_p retained
        start_op(16'd9, 16'd9, 1'b0);
        wait_valid(lat);
        held = bus.out_p;
        chk("t5_9x9", held, 32'd81);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flushd_valid", bus.out_valid, 0);
        chk("flushd_cnt", bus.done_cnt, exp_done % 256);
        chk("flushd_p_kept", bus.out_p, 32'd81);
        chk("flushd_busy", bus.busy, 0);

        // Asynchronous reset mid-MUL
        start_op(16'd4321, 16'd1234, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_p", bus.out_p, 0);
        chk("arst_done_cnt", bus.done_cnt, 0);
        exp_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 256 random results: done_cnt wraps back to zero
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'h8000;
                1: ra = 16'hFFFF;
                2: ra = 16'h0000;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 16'h7FFF;
                1: rb = 16'h0001;
                default: rb = 16'($urandom);
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), p0, p1);
        end
        chk("wrap_done_cnt", bus.done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
